// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: controller drives the master
// side, the timer owns the slave side.
interface countdown_timer_if #(
    parameter int W = 4
) ();
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         pause;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;

    modport master (
        output en, load, load_val, start, pause, auto_reload,
        input  count, busy, tc, done
    );

    modport slave (
        input  en, load, load_val, start, pause, auto_reload,
        output count, busy, tc, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable modulo down-counter with run/hold/done control, a combinational
// terminal-count strobe for cascading and a registered done pulse.
//
// state   | meaning
// IDLE    | stopped, count held, waiting for start
// RUN     | counting down on each en tick
// HOLD    | paused, count frozen until pause drops
// DONE    | one-shot expired at zero, waiting for start or load
module countdown_timer #(
    parameter int W      = 4,
    parameter int RELOAD = 9
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [W-1:0] RELOAD_V = W'(RELOAD);

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         tc_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= RELOAD_V;
            reload_q <= RELOAD_V;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_w     = (state_q == ST_RUN) && bus.en && !bus.pause && (count_q == '0);

        if (bus.load) begin
            // load wins over everything; a same-cycle start still launches the run
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            if (bus.start) begin
                state_d = ST_RUN;
            end else if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else if (bus.start && (state_q == ST_IDLE)) begin
            state_d = ST_RUN;
        end else if (bus.start && (state_q == ST_DONE)) begin
            state_d = ST_RUN;
            count_d = reload_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_HOLD;
                    end else if (bus.en) begin
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                        end else if (bus.auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!bus.pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
        done_d = tc_w;
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tc    = tc_w;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench for countdown_timer: directed scenarios plus random
// traffic, each cycle checked against a behavioural timer model.
module tb_countdown_timer;
    logic clk;
    logic reset;

    countdown_timer_if #(.W(4)) bus ();

    countdown_timer #(.W(4), .RELOAD(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit tc;
        int cnt;
        bit busy;
        bit done;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // behavioural model: running / paused / expired flags and plain integers
    int m_cnt;
    int m_rel;
    bit m_active;
    bit m_paused;
    bit m_expired;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 9;
        m_rel     = 9;
        m_active  = 0;
        m_paused  = 0;
        m_expired = 0;
    endtask

    task automatic cycle(input bit ld, input int lv, input bit st, input bit pz,
                         input bit e, input bit ar);
        exp_t x;
        bit   tc_now;
        @(negedge clk);
        bus.load        = ld;
        bus.load_val    = 4'(lv);
        bus.start       = st;
        bus.pause       = pz;
        bus.en          = e;
        bus.auto_reload = ar;
        tc_now = m_active && !m_paused && !pz && e && (m_cnt == 0);
        if (ld) begin
            m_cnt = lv;
            m_rel = lv;
            if (st) begin
                m_active = 1; m_paused = 0; m_expired = 0;
            end else if (m_expired) begin
                m_expired = 0;
            end
        end else if (st && !m_active) begin
            if (m_expired) m_cnt = m_rel;
            m_active = 1; m_paused = 0; m_expired = 0;
        end else if (m_active && m_paused) begin
            if (!pz) m_paused = 0;
        end else if (m_active) begin
            if (pz) m_paused = 1;
            else if (e) begin
                if (m_cnt != 0) m_cnt = m_cnt - 1;
                else if (ar) m_cnt = m_rel;
                else begin
                    m_active = 0; m_expired = 1;
                end
            end
        end
        x.tc   = tc_now;
        x.cnt  = m_cnt;
        x.busy = m_active;
        x.done = tc_now;
        sb_q.push_back(x);
    endtask

    task automatic idle_in();
        bus.load = 0; bus.load_val = 0; bus.start = 0;
        bus.pause = 0; bus.en = 0; bus.auto_reload = 0;
    endtask

    // monitor: tc checked before the edge, registered outputs just after it
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                x = sb_q[0];
                chk("tc", int'(bus.tc), int'(x.tc));
                @(posedge clk);
                #1;
                chk("count", int'(bus.count), x.cnt);
                chk("busy", int'(bus.busy), int'(x.busy));
                chk("done", int'(bus.done), int'(x.done));
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        int guard;
        idle_in();
        model_reset();
        reset = 1'b1;
        #12;
        chk("rst_count", int'(bus.count), 9);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        reset = 1'b0;

        // stays idle without start
        repeat (3) cycle(0, 0, 0, 0, 1, 0);

        // async reset mid-run at count 5
        cycle(1, 7, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #3;
        chk("pre_rst_count", int'(bus.count), 5);
        bus.en = 1;
        reset = 1'b1;
        #1;
        chk("async_count", int'(bus.count), 9);
        chk("async_busy", int'(bus.busy), 0);
        chk("async_done", int'(bus.done), 0);
        chk("async_tc", int'(bus.tc), 0);
        @(negedge clk);
        reset = 1'b0;
        idle_in();
        model_reset();
        repeat (3) cycle(0, 0, 0, 0, 1, 0);

        // one-shot from 3
        cycle(1, 3, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0, 1, 0);

        // auto-reload from 2, tick every third cycle
        cycle(1, 2, 1, 0, 0, 1);
        for (int i = 0; i < 27; i++) cycle(0, 0, 0, 0, (i % 3) == 2, 1);

        // pause at 6 with en toggling, then resume
        cycle(1, 6, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, i[0], 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // load during RUN with en, then expire, start+load in DONE, plain restart
        cycle(1, 7, 0, 0, 1, 0);
        repeat (9) cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 4, 1, 0, 1, 0);
        repeat (6) cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // max load value, then zero reload in periodic mode
        cycle(1, 15, 1, 0, 0, 0);
        repeat (18) cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 0, 1, 0, 0, 1);
        repeat (6) cycle(0, 0, 0, 0, 1, 1);

        // random traffic
        begin
            bit pz, ar;
            pz = 0; ar = 0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 9) == 0) pz = ~pz;
                if ($urandom_range(0, 19) == 0) ar = ~ar;
                cycle($urandom_range(0, 19) == 0,
                      (i < 400) ? $urandom_range(0, 3) : $urandom_range(0, 15),
                      $urandom_range(0, 11) == 0, pz,
                      $urandom_range(0, 1) == 1, ar);
            end
        end

        @(negedge clk);
        idle_in();
        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        chk("drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable modulo down-counter with run/hold/done control; the count-down counterpart of the team's modulo-n up-counter.
- Used for serve delays, round timers and cascaded multi-digit countdown displays.
- Advances only on a one-cycle tick enable from the shared prescaler.
- Provides a combinational terminal-count strobe for cascading, and a registered done pulse for the game FSM.

Parameters:
- W, 4, count width in bits.
- RELOAD, 9, reset value of count and of the internal reload register; must be < 2^W.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  tick enable; one decrement opportunity per cycle it is high.
- load  input  1  synchronous load strobe.
- load_val  input  W  value written to count and the reload register on load.
- start  input  1  begin or restart the countdown.
- pause  input  1  level; freezes the count while high in RUN/HOLD.
- auto_reload  input  1  level; 1 = periodic mode, 0 = one-shot.
- count  output  W  current count value (registered).
- busy  output  1  high in RUN or HOLD (registered).
- tc  output  1  combinational terminal count = (state==RUN) & en & ~pause & (count==0).
- done  output  1  registered one-cycle pulse, asserted the cycle after tc.

Behaviour:
- Reset (async, any time, including mid-count):
  - state=IDLE, count=RELOAD, reload_reg=RELOAD, busy=0, done=0.
  - Takes effect without waiting for clk.
- States: IDLE, RUN, HOLD, DONE (2-bit encoding).
- Priority per clock edge: load > start > pause > en.
- load, in any state:
  - count <= load_val, reload_reg <= load_val.
  - state unchanged, except DONE -> IDLE.
  - An en tick in the same cycle is ignored.
- start:
  - In IDLE: -> RUN; count unchanged.
  - In DONE: -> RUN with count <= reload_reg.
  - In RUN/HOLD: ignored.
  - start together with load: load applies, then state -> RUN.
- RUN, pause=1: -> HOLD; count frozen, en ignored.
- HOLD, pause=0: -> RUN on the next edge; no tick is lost or invented.
- RUN, en=1, pause=0, count!=0: count <= count-1.
- RUN, en=1, pause=0, count==0 (the tc cycle):
  - done=1 on the next cycle, for exactly 1 cycle.
  - auto_reload=1: count <= reload_reg, stay in RUN.
  - auto_reload=0: count stays 0, -> DONE.
- Period: reload_reg+1 en ticks per tc, matching a modulo-(reload_reg+1) counter.
- reload_reg=0 with auto_reload=1: tc on every en tick.
- IDLE, DONE: en ignored; count held.
- busy: registered; equals (next state is RUN or HOLD), so it rises with the first RUN cycle.
- No arithmetic underflow: count==0 never decrements; wrap occurs only via reload.
- tc is purely combinational, intended to drive the en of the next more-significant digit. It is never asserted outside RUN or while pause=1.

Test Plan:
- Reset mid-run: assert reset asynchronously between edges with count=5 in RUN -> count=9 (RELOAD), busy=0, done=0 before the next clk edge; stays IDLE after release.
- One-shot: load_val=3, load, start, then en every cycle -> count 3,2,1,0; tc high on the 4th tick; done high exactly one cycle later; state DONE, count holds 0, busy=0.
- Auto-reload: load_val=2, auto_reload=1, start, en every 3rd cycle for 9 ticks -> count 2,1,0,2,1,0,2,1,0; three tc pulses, each one en-cycle wide; busy stays 1.
- Pause: RUN at count=6, pause high for 5 cycles with en toggling -> count stays 6, state HOLD; after release, the next en tick gives count=5.
- Simultaneous events:
  - load(val=7) with en=1 in RUN -> count=7, no decrement.
  - start with load(val=4) in DONE -> RUN, count=4.
  - start in DONE without load -> count reloads the last load_val.
- Edge values: W=4, load_val=15 (max) -> 16 ticks to tc; load_val=0 with auto_reload=1 -> tc on every en tick.
